ps2_key_fifo: RTL and testbench
===============================

# ps2_key_fifo

Memory-mapped PS/2 keyboard receiver for the Pong SoC. Deserializes PS/2 device-to-host frames and folds E0 (extended) and F0 (break) prefixes into one key-event word. Queues events in a small FIFO that the picoVersat controller reads through the address decoder's data bus. Sits upstream of the data bus, beside `paddleController`, on the same `PS2C`/`PS2D` pins; game code uses it for menu, pause and reset keys.

## Interface
- `DATA_W`, 32: data bus width.
- `FIFO_DEPTH`, 4: event queue depth; must be a power of 2, at least 2.
- `TIMEOUT_CYC`, 5000: stalled-frame limit in `clk` cycles (100 µs at 50 MHz).

Ports:
- `clk`  in  1  system clock, 50 MHz.
- `rst`  in  1  reset, asynchronous, active-high.
- `ps2Clk`  in  1  raw PS/2 clock pin (asynchronous).
- `ps2Data`  in  1  raw PS/2 data pin (asynchronous).
- `sel`  in  1  block selected by the address decoder.
- `re`  in  1  read strobe (`sel & ~data_we` at top level).
- `addr`  in  1  0 = event register, 1 = status register.
- `data_out`  out  DATA_W  read data, combinational from `addr`.
- `irq`  out  1  high while the FIFO is non-empty.

## Operation
- Both pins pass through a 2-FF synchronizer. A registered copy of synced `ps2Clk` gives a one-cycle `fall` pulse on its 1→0 transition. Data is sampled only on `fall`.
- Frame FSM states and transitions:
  - IDLE → DATA on `fall` with data=0 (start bit). `fall` with data=1 is ignored.
  - DATA shifts 8 bits in, LSB first, then → PARITY.
  - PARITY samples the parity bit, then → STOP.
  - STOP → IDLE always. The byte is accepted only if the stop bit is 1 and the 9 bits {data, parity} have odd parity. Otherwise the byte is dropped and sticky `frame_err` is set.
- Prefix decoder, on each accepted byte:
  - 0xE0 sets `ext`.
  - 0xF0 sets `brk`.
  - Any other byte pushes the event {ext, brk, code} and clears `ext` and `brk`.
- Event word, addr 0:
  - bit 10 = valid (FIFO non-empty).
  - bit 9 = ext.
  - bit 8 = brk (1 = key release).
  - bits 7:0 = scan code.
  - All upper bits 0. The whole word is 0 when the FIFO is empty.
- Status word, addr 1:
  - bit 0 = empty.
  - bit 1 = full.
  - bit 2 = overflow (sticky).
  - bit 3 = frame_err (sticky).
  - Remaining bits 0.
- Pop: `sel & re & addr==0 & ~empty` advances the read pointer at the clock edge. A read while empty has no effect.
- Status read: `sel & re & addr==1` clears both sticky bits at the clock edge.
- Full FIFO plus push with no pop in the same cycle: the event is dropped and `overflow` is set. Push and pop in the same cycle while full: both succeed, no overflow.
- Sticky set and status-read clear in the same cycle: set wins.
- Pointers are log2(FIFO_DEPTH)+1 bits; full/empty are derived from the extra wrap bit.
- Reset mid-frame: the FSM returns to IDLE and the partial frame is lost.

## Timing
- Reset values:
  - FSM IDLE; bit counter 0.
  - `ext`, `brk`, `overflow`, `frame_err` 0.
  - Pointers 0.
  - `data_out` 0 at addr 0, 0x1 at addr 1.
  - `irq` 0.
- Pin-to-`fall` latency: 3 `clk` cycles.
- If `fall` for the stop bit occurs in cycle N, the event is written at the end of N. `irq`=1 and a valid `data_out` appear in N+1.
- A pop in cycle M shows the next entry (or 0) in M+1.
- `data_out` is combinational from `addr` and the FIFO head, with no read latency. This matches the decoder's combinational read mux.

## Configuration
- `PS2_TIMEOUT_EN` defined:
  - A counter runs while the FSM is not IDLE and is cleared on every `fall`.
  - When it reaches `TIMEOUT_CYC`, the FSM aborts to IDLE, `ext`/`brk` clear and `frame_err` is set.
- Undefined: no counter is built. A truncated frame waits indefinitely and resynchronizes only through later edges or reset.

## Test plan
- Press 'A': frame 0x1C with parity 0 and stop 1 → `irq`=1; addr 0 reads 0x41C; after the pop, addr 0 reads 0 and `irq`=0.
- Release 'A': frames F0, 1C → a single event 0x51C.
- Up arrow press then release: E0 75 → 0x675; E0 F0 75 → 0x775.
- Bad parity on 0x1C (parity bit 1) → no event; status reads 0x9; the next status read gives 0x1.
- Five events with no reads, depth 4 → status 0x6; the four oldest events pop in order; the fifth is lost.
- With `PS2_TIMEOUT_EN`: start bit plus 3 data bits, then `ps2Clk` held high for 5000 cycles → FSM returns to IDLE and `frame_err`=1; a following clean 0x29 frame yields 0x429.

Source files
------------

// File: rtl/ps2_key_fifo.sv
// PS/2 keyboard receiver: folds E0/F0 prefixes into key events and queues them in a FIFO.
// Define PS2_TIMEOUT_EN to build the stalled-frame abort counter.
module ps2_key_fifo #(
  parameter int DATA_W      = 32,
  parameter int FIFO_DEPTH  = 4,
  parameter int TIMEOUT_CYC = 5000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ps2Clk,
  input  logic              ps2Data,
  input  logic              sel,
  input  logic              re,
  input  logic              addr,
  output logic [DATA_W-1:0] data_out,
  output logic              irq
);
  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;
  state_t state, state_next;

  logic       clk_s1, clk_s2, clk_d, dat_s1, dat_s2, fall;
  logic [2:0] bit_cnt;
  logic [7:0] shift;
  logic       par_bit;
  logic       ext, brk, overflow, frame_err;
  logic [AW:0] wptr, rptr;
  logic [9:0] mem [FIFO_DEPTH];
  logic       empty, full, byte_ok, byte_bad, push_req, pop, do_push;
  logic       ovf_set, ferr_set, status_rd, tmo_hit;

  // Synchronizers idle high so reset release never fakes a falling edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_s1 <= 1'b1; clk_s2 <= 1'b1; clk_d <= 1'b1;
      dat_s1 <= 1'b1; dat_s2 <= 1'b1;
    end else begin
      clk_s1 <= ps2Clk;  clk_s2 <= clk_s1; clk_d <= clk_s2;
      dat_s1 <= ps2Data; dat_s2 <= dat_s1;
    end
  end
  assign fall = clk_d & ~clk_s2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (fall && !dat_s2) state_next = DATA;
      DATA:    if (fall && bit_cnt == 3'd7) state_next = PARITY;
      PARITY:  if (fall) state_next = STOP;
      STOP:    if (fall) state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (tmo_hit) state_next = IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_cnt <= '0;
      shift   <= '0;
      par_bit <= 1'b0;
    end else begin
      if (state == IDLE) bit_cnt <= '0;
      else if (state == DATA && fall) begin
        shift   <= {dat_s2, shift[7:1]};
        bit_cnt <= bit_cnt + 3'd1;
      end
      if (state == PARITY && fall) par_bit <= dat_s2;
    end
  end

  assign byte_ok  = (state == STOP) && fall && dat_s2 && (^{shift, par_bit});
  assign byte_bad = (state == STOP) && fall && !(dat_s2 && (^{shift, par_bit}));
  assign push_req = byte_ok && shift != 8'hE0 && shift != 8'hF0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ext <= 1'b0;
      brk <= 1'b0;
    end else if (tmo_hit) begin
      ext <= 1'b0;
      brk <= 1'b0;
    end else if (byte_ok) begin
      if (shift == 8'hE0)      ext <= 1'b1;
      else if (shift == 8'hF0) brk <= 1'b1;
      else begin
        ext <= 1'b0;
        brk <= 1'b0;
      end
    end
  end

  assign empty     = (wptr == rptr);
  assign full      = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign pop       = sel & re & ~addr & ~empty;
  // A pop in the same cycle frees the slot the push lands in.
  assign ovf_set   = push_req & full & ~pop;
  assign do_push   = push_req & ~ovf_set;
  assign status_rd = sel & re & addr;
  assign ferr_set  = byte_bad | tmo_hit;

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr[AW-1:0]] <= {ext, brk, shift};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr      <= '0;
      rptr      <= '0;
      overflow  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (pop)     rptr <= rptr + 1'b1;
      if (ovf_set)        overflow <= 1'b1;
      else if (status_rd) overflow <= 1'b0;
      if (ferr_set)       frame_err <= 1'b1;
      else if (status_rd) frame_err <= 1'b0;
    end
  end

`ifdef PS2_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] tmo_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                        tmo_cnt <= '0;
    else if (state == IDLE || fall) tmo_cnt <= '0;
    else                            tmo_cnt <= tmo_cnt + 1'b1;
  end
  assign tmo_hit = (state != IDLE) && (tmo_cnt == TW'(TIMEOUT_CYC));
`else
  assign tmo_hit = 1'b0;
`endif

  always_comb begin
    data_out = '0;
    if (addr)        data_out[3:0]  = {frame_err, overflow, full, empty};
    else if (!empty) data_out[10:0] = {1'b1, mem[rptr[AW-1:0]]};
  end
  assign irq = ~empty;
endmodule

// File: tb/tb_ps2_key_fifo.sv
// Self-checking bench for ps2_key_fifo: directed test-plan cases plus random traffic vs a queue model.
module tb_ps2_key_fifo;
  localparam int DEPTH = 4;
  localparam int TMO   = 5000;

  logic        clk = 1'b0, rst, ps2_clk, ps2_data, sel, re, addr, irq;
  logic [31:0] data_out;
  int unsigned n_cmp = 0, n_bad = 0;

  // Reference model: event queue plus prefix and sticky flags.
  logic [9:0] q[$];
  bit m_ext, m_brk, m_ovf, m_ferr;

  ps2_key_fifo #(.DATA_W(32), .FIFO_DEPTH(DEPTH), .TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .rst(rst), .ps2Clk(ps2_clk), .ps2Data(ps2_data),
    .sel(sel), .re(re), .addr(addr), .data_out(data_out), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] exp_event();
    return (q.size() == 0) ? 32'h0 : {21'h0, 1'b1, q[0]};
  endfunction

  function automatic logic [31:0] exp_status();
    return {28'h0, m_ferr, m_ovf, q.size() == DEPTH, q.size() == 0};
  endfunction

  task automatic model_reset();
    q.delete();
    m_ext = 0; m_brk = 0; m_ovf = 0; m_ferr = 0;
  endtask

  task automatic ps2_bit(input logic b);
    ps2_data = b;
    tick(10);
    ps2_clk = 1'b0;
    tick(10);
    ps2_clk = 1'b1;
  endtask

  // One frame; pop_at_stop asserts an event-register pop in exactly the cycle the byte is pushed.
  task automatic send(input logic [7:0] b, input bit bad_par = 0, input bit pop_at_stop = 0);
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i]);
    ps2_bit((~^b) ^ bad_par);
    ps2_data = 1'b1;
    tick(10);
    ps2_clk = 1'b0;
    if (pop_at_stop) begin
      tick(2);
      sel = 1'b1; re = 1'b1; addr = 1'b0;
      tick(1);
      sel = 1'b0; re = 1'b0;
      tick(7);
      if (q.size() > 0) void'(q.pop_front());
    end else tick(10);
    ps2_clk = 1'b1;
    tick(10);
    if (bad_par) m_ferr = 1;
    else if (b == 8'hE0) m_ext = 1;
    else if (b == 8'hF0) m_brk = 1;
    else begin
      if (q.size() < DEPTH) q.push_back({m_ext, m_brk, b});
      else m_ovf = 1;
      m_ext = 0; m_brk = 0;
    end
  endtask

  task automatic peek(input string tag, input logic a, input logic [31:0] exp);
    addr = a;
    #1;
    check(tag, data_out, exp);
  endtask

  task automatic read(input logic a);
    addr = a; sel = 1'b1; re = 1'b1;
    tick(1);
    sel = 1'b0; re = 1'b0;
    if (a) begin m_ovf = 0; m_ferr = 0; end
    else if (q.size() > 0) void'(q.pop_front());
  endtask

  task automatic partial_frame();
    ps2_bit(1'b0);
    for (int i = 0; i < 3; i++) ps2_bit(1'($urandom_range(0, 1)));
  endtask

  initial begin
    rst = 1'b1; ps2_clk = 1'b1; ps2_data = 1'b1; sel = 1'b0; re = 1'b0; addr = 1'b0;
    model_reset();
    tick(3);
    peek("rst_event", 1'b0, 32'h0);
    peek("rst_status", 1'b1, 32'h1);
    check("rst_irq", {31'h0, irq}, 32'h0);
    rst = 1'b0;
    tick(3);

    send(8'h1C);
    check("pressA_irq", {31'h0, irq}, 32'h1);
    peek("pressA", 1'b0, 32'h41C);
    read(1'b0);
    peek("pressA_popped", 1'b0, 32'h0);
    check("pressA_irq_clr", {31'h0, irq}, 32'h0);

    send(8'hF0); send(8'h1C);
    peek("releaseA", 1'b0, 32'h51C);
    read(1'b0);
    peek("releaseA_single", 1'b0, 32'h0);

    send(8'hE0); send(8'h75);
    peek("up_press", 1'b0, 32'h675);
    read(1'b0);
    send(8'hE0); send(8'hF0); send(8'h75);
    peek("up_release", 1'b0, 32'h775);
    read(1'b0);

    send(8'h1C, 1);
    peek("badpar_noevent", 1'b0, 32'h0);
    peek("badpar_status", 1'b1, 32'h9);
    read(1'b1);
    peek("badpar_cleared", 1'b1, 32'h1);

    for (int i = 0; i < 5; i++) send(8'h10 + 8'(i));
    peek("ovf_status", 1'b1, 32'h6);
    read(1'b1);
    for (int i = 0; i < 4; i++) begin
      peek("ovf_order", 1'b0, 32'h410 + i);
      read(1'b0);
    end
    peek("ovf_fifth_lost", 1'b0, 32'h0);
    peek("ovf_cleared", 1'b1, 32'h1);

    for (int i = 0; i < 4; i++) send(8'h20 + 8'(i));
    send(8'h24, 0, 1);
    peek("full_pushpop_status", 1'b1, 32'h2);
    for (int i = 1; i < 5; i++) begin
      peek("full_pushpop_order", 1'b0, 32'h420 + i);
      read(1'b0);
    end

    send(8'hF0);
    partial_frame();
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    model_reset();
    ps2_data = 1'b1;
    tick(5);
    peek("midrst_status", 1'b1, 32'h1);
    send(8'h29);
    peek("midrst_clean", 1'b0, 32'h429);
    read(1'b0);

`ifdef PS2_TIMEOUT_EN
    send(8'hE0);
    partial_frame();
    ps2_data = 1'b1;
    tick(TMO + 20);
    m_ext = 0; m_brk = 0; m_ferr = 1;
    peek("tmo_status", 1'b1, 32'h9);
    read(1'b1);
    send(8'h29);
    peek("tmo_recover", 1'b0, 32'h429);
    read(1'b0);
`endif

    for (int n = 0; n < 60; n++) begin
      int unsigned op;
      logic [7:0] code;
      op = $urandom_range(0, 9);
      if (op <= 4) begin
        do code = 8'($urandom_range(0, 255)); while (code == 8'hE0 || code == 8'hF0);
        if ($urandom_range(0, 1) == 1) send(8'hE0);
        if ($urandom_range(0, 2) == 0) send(8'hF0);
        send(code);
      end else if (op == 5) begin
        send(8'($urandom_range(0, 255)), 1);
      end else if (op <= 7) begin
        peek("rnd_event", 1'b0, exp_event());
        read(1'b0);
      end else if (op == 8) begin
        peek("rnd_status", 1'b1, exp_status());
        read(1'b1);
      end else begin
        check("rnd_irq", {31'h0, irq}, {31'h0, q.size() != 0});
      end
    end
    while (q.size() > 0) begin
      peek("drain_event", 1'b0, exp_event());
      read(1'b0);
    end
    peek("final_status", 1'b1, exp_status());

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
